hbridge_pwm_gen: RTL

- Consumes the two unsigned magnitude commands from the balance controller: Duty_l for forward and Duty_r for reverse, each 16-bit and saturated upstream at 7500.
- Produces registered, glitch-free PWM drive for the two legs of one H-bridge: In1 is the forward leg and In2 is the reverse leg.
- Duty values are double-buffered. They take effect only at PWM period boundaries.
- Sits between the control loop and the motor-driver pins.

---
 rtl/motor_pkg.sv | 25 ++
 rtl/pwm_tick_counter.sv | 41 ++++
 rtl/hbridge_pwm_gen.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/motor_pkg.sv
// Shared motor-drive types and constants.
// Used by the PWM generator and the balance controller saturation.
package motor_pkg;

    localparam int PWM_PERIOD_DEF = 7500;
    localparam int DUTY_MAX       = 7500;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } pwm_state_e;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    // Saturate a duty magnitude to the period length.
    function automatic logic [15:0] clamp_duty(
        input logic [15:0] duty,
        input logic [15:0] lim
    );
        return (duty > lim) ? lim : duty;
    endfunction

endpackage

// File: rtl/pwm_tick_counter.sv
// Prescaler plus PWM period counter.
// Held at zero whenever Run is low.
module pwm_tick_counter
    import motor_pkg::*;
#(
    parameter int PERIOD   = PWM_PERIOD_DEF,
    parameter int PRESCALE = 4,
    parameter int CW       = 16
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Run,
    output logic          Tick,
    output logic [CW-1:0] Count,
    output logic          Wrap
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_q;

    assign Tick = Run && (pre_q == PW'(PRESCALE - 1));
    assign Wrap = Tick && (Count == CW'(PERIOD - 1));

    // Prescaler and period counter; counter moves only on a tick.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pre_q <= '0;
            Count <= '0;
        end else if (!Run) begin
            pre_q <= '0;
            Count <= '0;
        end else begin
            pre_q <= Tick ? '0 : pre_q + PW'(1);
            if (Tick) begin
                Count <= Wrap ? '0 : Count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/hbridge_pwm_gen.sv
// Double-buffered PWM drive for one H-bridge (In1 fwd, In2 rev).
// Optional reversal dead period: define HBRIDGE_DEADTIME_EN.
module hbridge_pwm_gen
    import motor_pkg::*;
#(
    parameter int PERIOD   = PWM_PERIOD_DEF,
    parameter int PRESCALE = 4,
    parameter int CW       = 16
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          En,
    input  logic [CW-1:0] Duty_l,
    input  logic [CW-1:0] Duty_r,
    output logic          In1,
    output logic          In2,
    output logic          Period_start,
    output logic          Fault,
    output logic          Dir
);

    pwm_state_e state_q;
    pwm_state_e state_d;

    logic          tick;
    logic          wrap;
    logic          per_end;
    logic          run_en;
    logic [CW-1:0] cnt;
    logic [CW-1:0] sl_q;
    logic [CW-1:0] sr_q;
    logic [CW-1:0] cl;
    logic [CW-1:0] cr;
    logic          fwd_nz;
    logic          rev_nz;
    logic          both_nz;
    logic          load;
    logic          to_dead;

    assign run_en  = (state_q != IDLE) && En;
    assign per_end = tick && wrap;

    assign cl = (Duty_l > CW'(PERIOD)) ? CW'(PERIOD) : Duty_l;
    assign cr = (Duty_r > CW'(PERIOD)) ? CW'(PERIOD) : Duty_r;

    assign fwd_nz  = (cl != '0);
    assign rev_nz  = (cr != '0);
    assign both_nz = fwd_nz && rev_nz;

    pwm_tick_counter #(
        .PERIOD   (PERIOD),
        .PRESCALE (PRESCALE),
        .CW       (CW)
    ) u_cnt (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Run   (run_en),
        .Tick  (tick),
        .Count (cnt),
        .Wrap  (wrap)
    );

`ifdef HBRIDGE_DEADTIME_EN
    logic act_q;
    logic reversal;

    assign reversal = act_q && !both_nz && (fwd_nz || rev_nz)
                    && (fwd_nz != Dir);

    // Remembers that a direction has actually been driven since enable.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            act_q <= 1'b0;
        end else if (!En) begin
            act_q <= 1'b0;
        end else if (load && !both_nz && !to_dead) begin
            act_q <= act_q || fwd_nz || rev_nz;
        end
    end
`endif

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and shadow-load strobe.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        to_dead = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (En) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (!En) begin
                    state_d = IDLE;
                end else if (per_end) begin
                    load = 1'b1;
`ifdef HBRIDGE_DEADTIME_EN
                    if (reversal) begin
                        to_dead = 1'b1;
                        state_d = DEAD;
                    end
`endif
                end
            end
`ifdef HBRIDGE_DEADTIME_EN
            DEAD: begin
                if (!En) begin
                    state_d = IDLE;
                end else if (per_end) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Shadow duties, sticky fault and direction, updated at loads.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sl_q  <= '0;
            sr_q  <= '0;
            Fault <= 1'b0;
            Dir   <= DIR_REV;
        end else if (!En) begin
            sl_q  <= '0;
            sr_q  <= '0;
            Fault <= 1'b0;
            Dir   <= DIR_REV;
        end else if (load) begin
            if (both_nz) begin
                sl_q  <= '0;
                sr_q  <= '0;
                Fault <= 1'b1;
            end else if (to_dead) begin
                sl_q <= '0;
                sr_q <= '0;
            end else begin
                sl_q <= cl;
                sr_q <= cr;
                if (fwd_nz) begin
                    Dir <= DIR_FWD;
                end else if (rev_nz) begin
                    Dir <= DIR_REV;
                end
            end
        end
    end

    // Registered pins: compare lags the counter by one clock.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            In1          <= 1'b0;
            In2          <= 1'b0;
            Period_start <= 1'b0;
        end else begin
            In1          <= run_en && (cnt < sl_q);
            In2          <= run_en && (cnt < sr_q);
            Period_start <= load;
        end
    end

endmodule
